// File: rtl/beams_pick_ctrl.sv
// Beam pick controller: buffers per-RBG sort results in a 2-entry FIFO and
// presents them to the pick datapath at each RBG start, tracking symbols.
module beams_pick_ctrl #(
  parameter int unsigned RBG_BEATS = 48,
  parameter int unsigned SYM_NUM   = 14
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sort_vld,
  input  logic [15:0][7:0]  i_sort_idx,
  input  logic [15:0][31:0] i_sort_pwr,
  output logic              o_sort_rdy,
  input  logic              i_data_vld,
  input  logic              i_data_eop,
  output logic [15:0][7:0]  o_sort_idx,
  output logic [15:0][31:0] o_sort_pwr,
  output logic              o_sort_sop,
  output logic              o_rbg_load,
  output logic              o_sym_1st,
  output logic [3:0]        o_sym_cnt,
  output logic              o_err_udf,
  output logic              o_err_eop
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [7:0] BEAT_LAST = 8'(RBG_BEATS - 1);
  localparam logic [3:0] SYM_LAST  = 4'(SYM_NUM - 1);

  logic [0:0]              state, state_nxt;
  logic [7:0]              beat_cnt, beat_nxt;
  logic [1:0]              fifo_cnt;
  logic                    wr_ptr, rd_ptr;
  logic [1:0][15:0][7:0]   fifo_idx;
  logic [1:0][15:0][31:0]  fifo_pwr;
  logic                    rbg_start, sym_end, push, pop;

  // Ready depends only on registered occupancy; a full FIFO never takes a push.
  assign o_sort_rdy = (fifo_cnt < 2'd2);

  // Next state, beat counter and FIFO handshakes.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    rbg_start = i_data_vld && (beat_cnt == 8'd0);
    sym_end   = i_data_vld && i_data_eop;
    push      = i_sort_vld && o_sort_rdy;
    pop       = rbg_start && (fifo_cnt != 2'd0);
    if (i_data_vld) begin
      beat_nxt = (beat_cnt == BEAT_LAST) ? 8'd0 : beat_cnt + 8'd1;
    end
    case (state)
      ST_IDLE: if (i_data_vld) state_nxt = ST_RUN;
      ST_RUN:  ;
      default: state_nxt = ST_IDLE;
    endcase
    // End of symbol wins, including an eop on the very first beat.
    if (sym_end) begin
      state_nxt = ST_IDLE;
      beat_nxt  = 8'd0;
    end
  end

  // State, counters, outputs and error flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      beat_cnt   <= 8'd0;
      fifo_cnt   <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      o_sort_idx <= '0;
      o_sort_pwr <= '0;
      o_sort_sop <= 1'b0;
      o_rbg_load <= 1'b0;
      o_sym_1st  <= 1'b0;
      o_sym_cnt  <= 4'd0;
      o_err_udf  <= 1'b0;
      o_err_eop  <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_nxt;
      o_rbg_load <= rbg_start;
      o_sort_sop <= i_data_vld && (state == ST_IDLE);
      o_sym_1st  <= (o_sym_cnt == 4'd0) && ((state == ST_RUN) || i_data_vld);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        o_sort_idx <= fifo_idx[rd_ptr];
        o_sort_pwr <= fifo_pwr[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (sym_end) o_sym_cnt <= (o_sym_cnt == SYM_LAST) ? 4'd0 : o_sym_cnt + 4'd1;
      if (rbg_start && (fifo_cnt == 2'd0)) o_err_udf <= 1'b1;
      if (sym_end && (beat_cnt != BEAT_LAST)) o_err_eop <= 1'b1;
    end
  end

  // FIFO storage needs no reset; occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (i_sort_vld && o_sort_rdy) begin
      fifo_idx[wr_ptr] <= i_sort_idx;
      fifo_pwr[wr_ptr] <= i_sort_pwr;
    end
  end

endmodule

// File: doc/beams_pick_ctrl.md
BEAMS_PICK_CTRL -- requirements
Module: beams_pick_ctrl

Interface
REQ-001 SHALL have parameter RBG_BEATS, default 48: number of i_data_vld beats per RBG; legal range 2..255.
REQ-002 SHALL have parameter SYM_NUM, default 14: symbols per slot; legal range 1..15.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_reset, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port i_sort_vld, input, 1 bit: sort result for one RBG is valid; accepted when i_sort_vld && o_sort_rdy.
REQ-006 SHALL have port i_sort_idx, input, [15:0][7:0]: 16 sorted beam indices.
REQ-007 SHALL have port i_sort_pwr, input, [15:0][31:0]: 16 sorted beam powers.
REQ-008 SHALL have port o_sort_rdy, output, 1 bit: high when the result FIFO is not full.
REQ-009 SHALL have port i_data_vld, input, 1 bit: one beam-data beat to the pick datapath.
REQ-010 SHALL have port i_data_eop, input, 1 bit: last beat of a symbol; qualified by i_data_vld.
REQ-011 SHALL have port o_sort_idx, output, [15:0][7:0]: index set for the current RBG.
REQ-012 SHALL have port o_sort_pwr, output, [15:0][31:0]: power set for the current RBG.
REQ-013 SHALL have port o_sort_sop, output, 1 bit: one-cycle pulse on the first RBG load of each symbol.
REQ-014 SHALL have port o_rbg_load, output, 1 bit: one-cycle pulse on each RBG load.
REQ-015 SHALL have port o_sym_1st, output, 1 bit: high while symbol 0 of the slot is in progress.
REQ-016 SHALL have port o_sym_cnt, output, 4 bits: index of the current symbol, 0..SYM_NUM-1.
REQ-017 SHALL have port o_err_udf, output, 1 bit: sticky flag, RBG start with the FIFO empty.
REQ-018 SHALL have port o_err_eop, output, 1 bit: sticky flag, i_data_eop not on an RBG boundary.

Function
REQ-019 SHALL hold sort results in a 2-entry FIFO; push on i_sort_vld && o_sort_rdy; o_sort_rdy = (count < 2), combinational from registered state.
REQ-020 SHALL implement states IDLE and RUN; IDLE -> RUN on any i_data_vld; RUN -> IDLE on i_data_vld && i_data_eop.
REQ-021 SHALL keep an 8-bit beat counter: cleared in IDLE; in RUN, counts qualified beats 0..RBG_BEATS-1, then wraps to 0.
REQ-022 SHALL define an RBG start as a qualified beat with the counter at 0, including the IDLE -> RUN beat.
REQ-023 SHALL pop the FIFO on each RBG start and register the head onto o_sort_idx/o_sort_pwr; latency 1 cycle.
REQ-024 SHALL pulse o_rbg_load in the cycle after each RBG start.
REQ-025 SHALL pulse o_sort_sop together with o_rbg_load for the first RBG start of each symbol only.
REQ-026 SHALL allow a push and a pop in the same cycle; count is then unchanged.
REQ-027 SHALL accept a push into a full FIFO when a pop occurs in the same cycle only via o_sort_rdy; o_sort_rdy stays low when full, with no bypass.
REQ-028 SHALL handle an RBG start with the FIFO empty (underflow) as follows: o_sort_idx/o_sort_pwr hold their previous values, o_rbg_load still pulses, o_err_udf sets.
REQ-029 SHALL handle i_data_eop on a beat where the counter is not RBG_BEATS-1 as follows: o_err_eop sets, and the symbol still terminates.
REQ-030 SHALL treat an RBG start that also carries i_data_eop as a complete symbol: load, then return to IDLE.
REQ-031 SHALL, on each symbol end, increment o_sym_cnt with wrap from SYM_NUM-1 to 0; o_sym_cnt updates 1 cycle after the eop beat.
REQ-032 SHALL register o_sym_1st high when o_sym_cnt == 0 and the state is RUN (or entering RUN), low otherwise.
REQ-033 SHALL clear error flags only by reset.

Reset
REQ-034 SHALL, while i_reset is high at a clock edge, drive: FIFO empty, o_sort_rdy=1 the next cycle, state IDLE, beat counter 0, o_sym_cnt 0, o_sort_idx/o_sort_pwr 0, o_sort_sop 0, o_rbg_load 0, o_sym_1st 0, o_err_udf 0, o_err_eop 0.
REQ-035 SHALL make reset mid-symbol abort the symbol and discard FIFO contents; operation resumes from symbol 0.

Verification
REQ-036 SHALL be verified with: RBG_BEATS=4, two sort pushes, 8 beats with eop on beat 8 -> rbg_load pulses after beats 1 and 5, sort_sop only after beat 1, sym_cnt 0->1, sym_1st high during beats 1-8.
REQ-037 SHALL be verified with: three back-to-back pushes with no data -> o_sort_rdy low after the 2nd push, 3rd held until the first RBG start pops.
REQ-038 SHALL be verified with: data beat with FIFO empty -> rbg_load pulses, outputs keep 0 after reset, err_udf=1.
REQ-039 SHALL be verified with: eop on beat 3 of RBG_BEATS=4 -> err_eop=1, state IDLE, next beat issues sort_sop.
REQ-040 SHALL be verified with: SYM_NUM=14, 14 symbols -> sym_cnt wraps 13->0, sym_1st reasserts on symbol 15.
REQ-041 SHALL be verified with: reset asserted mid-RBG with FIFO count 2 -> all outputs zero, o_sort_rdy=1, next beat underflows.
